// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, IR capture pattern,
// BYPASS opcode helper and the TAP next-state graph.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // All-ones opcode of the given instruction width.
  function automatic logic [31:0] bypass_opcode(input int unsigned ir_width);
    return (32'd1 << ir_width) - 32'd1;
  endfunction

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_RESET;
    case (s)
      TAP_RESET:      n = tms ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  n = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        n = TAP_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// STAGES-deep flop chain bringing one asynchronous pin into the clk domain.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jtag_tap_port.sv
// Oversampled JTAG TAP: pin synchronizers, TCK edge detection, IEEE 1149.1
// controller, instruction register and NUM_DR user data registers plus BYPASS.
module jtag_tap_port
  import jtag_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IR_WIDTH    = 4,
  parameter int unsigned DR_WIDTH    = 16,
  parameter int unsigned NUM_DR      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tck_in,
  input  logic                       tdi_in,
  input  logic                       tms_in,
  output logic                       tdo,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture_data,
  output logic [DR_WIDTH-1:0]        dr_update_data,
  output logic [IR_WIDTH-1:0]        dr_update_sel,
  output logic                       dr_update_vld,
  output logic [IR_WIDTH-1:0]        ir_value,
  output logic [3:0]                 tap_state
);

  localparam int unsigned          MASK_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [MASK_W-1:0]    MASK_INIT = MASK_W'(SYNC_STAGES + 1);
  localparam logic [IR_WIDTH-1:0]  IR_BYPASS = IR_WIDTH'(bypass_opcode(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0]  IR_CAP    = IR_WIDTH'(IR_CAPTURE);

  logic tck_s, tdi_s, tms_s;
  logic tck_prev_q;
  logic [MASK_W-1:0] mask_q;
  logic rise_c, fall_c;
  logic user_sel_c;
  logic [DR_WIDTH-1:0] cap_slice_c;

  tap_state_e          state_q;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] dr_sr_q;
  logic                byp_q;
  logic                tdo_q;
  logic [DR_WIDTH-1:0] upd_data_q;
  logic [IR_WIDTH-1:0] upd_sel_q;
  logic                upd_vld_q;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_tck (.clk(clk), .rst(rst), .d_i(tck_in), .q_o(tck_s));
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_tdi (.clk(clk), .rst(rst), .d_i(tdi_in), .q_o(tdi_s));
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_tms (.clk(clk), .rst(rst), .d_i(tms_in), .q_o(tms_s));

  // Edge mask hides the synchronizer filling up after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_prev_q <= 1'b0;
      mask_q     <= MASK_INIT;
    end else begin
      tck_prev_q <= tck_s;
      if (mask_q != '0) begin
        mask_q <= mask_q - MASK_W'(1);
      end
    end
  end

  assign rise_c = tck_s & ~tck_prev_q & (mask_q == '0);
  assign fall_c = ~tck_s & tck_prev_q & (mask_q == '0);

  assign user_sel_c = (32'(ir_q) < 32'(NUM_DR));

  always_comb begin
    cap_slice_c = '0;
    for (int k = 0; k < int'(NUM_DR); k++) begin
      if (ir_q == IR_WIDTH'(k)) begin
        cap_slice_c = dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
      end
    end
  end

  // TAP controller; register actions belong to the state being left on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TAP_RESET;
      ir_sr_q    <= '0;
      ir_q       <= IR_BYPASS;
      dr_sr_q    <= '0;
      byp_q      <= 1'b0;
      tdo_q      <= 1'b0;
      upd_data_q <= '0;
      upd_sel_q  <= '0;
      upd_vld_q  <= 1'b0;
    end else begin
      upd_vld_q <= 1'b0;
      if (rise_c) begin
        state_q <= tap_next(state_q, tms_s);
        case (state_q)
          TAP_CAPTURE_IR: ir_sr_q <= IR_CAP;
          TAP_SHIFT_IR:   ir_sr_q <= (ir_sr_q >> 1) | (IR_WIDTH'(tdi_s) << (IR_WIDTH - 1));
          TAP_UPDATE_IR:  ir_q    <= ir_sr_q;
          TAP_CAPTURE_DR: begin
            if (user_sel_c) dr_sr_q <= cap_slice_c;
            else            byp_q   <= 1'b0;
          end
          TAP_SHIFT_DR: begin
            if (user_sel_c) dr_sr_q <= (dr_sr_q >> 1) | (DR_WIDTH'(tdi_s) << (DR_WIDTH - 1));
            else            byp_q   <= tdi_s;
          end
          TAP_UPDATE_DR: begin
            if (user_sel_c) begin
              upd_data_q <= dr_sr_q;
              upd_sel_q  <= ir_q;
              upd_vld_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (fall_c) begin
        if (state_q == TAP_SHIFT_IR)      tdo_q <= ir_sr_q[0];
        else if (state_q == TAP_SHIFT_DR) tdo_q <= user_sel_c ? dr_sr_q[0] : byp_q;
        else                              tdo_q <= 1'b0;
      end
      if (state_q == TAP_RESET) begin
        ir_q    <= IR_BYPASS;
        dr_sr_q <= '0;
      end
    end
  end

  assign tdo            = tdo_q;
  assign dr_update_data = upd_data_q;
  assign dr_update_sel  = upd_sel_q;
  assign dr_update_vld  = upd_vld_q;
  assign ir_value       = ir_q;
  assign tap_state      = state_q;

endmodule

// File: tb/tb_jtag_tap_port.sv
// Directed bench for jtag_tap_port with a TCK-level behavioural model.
module tb_jtag_tap_port;

  localparam int unsigned SS  = 2;
  localparam int unsigned IRW = 4;
  localparam int unsigned DRW = 16;
  localparam int unsigned ND  = 4;
  localparam int          PH  = 6;

  localparam logic [3:0] S_SHDR = 4'h2, S_UPDDR = 4'h5, S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHIR = 4'hA, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR = 4'hF;
  // Next-state tables, one nibble per current state (state 0 in the low nibble).
  localparam logic [63:0] NX0 = 64'hCACC_BABA_62CE_3232;
  localparam logic [63:0] NX1 = 64'hF977_89DD_417F_0155;

  logic clk, rst, tck_in, tdi_in, tms_in, tdo, dr_update_vld;
  logic [ND*DRW-1:0] dr_capture_data;
  logic [DRW-1:0] dr_update_data;
  logic [IRW-1:0] dr_update_sel, ir_value;
  logic [3:0] tap_state;

  jtag_tap_port #(.SYNC_STAGES(SS), .IR_WIDTH(IRW), .DR_WIDTH(DRW), .NUM_DR(ND)) dut (
    .clk(clk), .rst(rst), .tck_in(tck_in), .tdi_in(tdi_in), .tms_in(tms_in), .tdo(tdo),
    .dr_capture_data(dr_capture_data), .dr_update_data(dr_update_data),
    .dr_update_sel(dr_update_sel), .dr_update_vld(dr_update_vld),
    .ir_value(ir_value), .tap_state(tap_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vld_seen = 0;

  logic [3:0]     m_state, m_ir, m_irsr, m_upd_sel;
  logic [DRW-1:0] m_dr, m_upd_data;
  logic           m_byp, m_tdo;
  int             m_pulses = 0;
  logic [31:0]    col;
  int             ncol;

  always @(negedge clk) if (dr_update_vld === 1'b1) vld_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_next(input logic [3:0] s, input logic tms);
    logic [63:0] t;
    t = tms ? NX1 : NX0;
    return t[int'(s)*4 +: 4];
  endfunction

  task automatic model_reset();
    m_state = S_TLR; m_ir = 4'hF; m_irsr = '0; m_dr = '0; m_byp = 1'b0;
    m_tdo = 1'b0; m_upd_data = '0; m_upd_sel = '0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    logic user;
    user = (m_ir < 4'(ND));
    case (m_state)
      S_CAPIR: m_irsr = 4'b0001;
      S_SHIR:  m_irsr = {tdi, m_irsr[3:1]};
      S_UPDIR: m_ir = m_irsr;
      S_CAPDR: if (user) m_dr = dr_capture_data[int'(m_ir)*DRW +: DRW]; else m_byp = 1'b0;
      S_SHDR:  if (user) m_dr = {tdi, m_dr[DRW-1:1]}; else m_byp = tdi;
      S_UPDDR: if (user) begin m_upd_data = m_dr; m_upd_sel = m_ir; m_pulses++; end
      default: ;
    endcase
    m_state = m_next(m_state, tms);
    if (m_state == S_TLR) begin m_ir = 4'hF; m_dr = '0; end
  endtask

  task automatic model_fall();
    if (m_state == S_SHIR)      m_tdo = m_irsr[0];
    else if (m_state == S_SHDR) m_tdo = (m_ir < 4'(ND)) ? m_dr[0] : m_byp;
    else                        m_tdo = 1'b0;
  endtask

  // Compare process: runs at every settled point of the TCK waveform.
  task automatic check_all(input string tag);
    chk({tag, ".tap_state"}, 32'(tap_state), 32'(m_state));
    chk({tag, ".ir_value"},  32'(ir_value), 32'(m_ir));
    chk({tag, ".tdo"},       32'(tdo), 32'(m_tdo));
    chk({tag, ".upd_data"},  32'(dr_update_data), 32'(m_upd_data));
    chk({tag, ".upd_sel"},   32'(dr_update_sel), 32'(m_upd_sel));
    chk({tag, ".vld_count"}, 32'(vld_seen), 32'(m_pulses));
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi);
    logic was_shift;
    tms_in = tms; tdi_in = tdi;
    wait_clks(PH);
    tck_in = 1'b1; model_rise(tms, tdi);
    wait_clks(PH);
    check_all("rise");
    was_shift = (m_state == S_SHIR) || (m_state == S_SHDR);
    tck_in = 1'b0; model_fall();
    wait_clks(PH);
    check_all("fall");
    if (was_shift && ncol < 32) begin col[ncol] = tdo; ncol++; end
  endtask

  task automatic tlr5();
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
  endtask

  task automatic scan_ir(input logic [3:0] v);
    ncol = 0; col = '0;
    tck_cycle(1'b0, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, v[i]);
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [31:0] bits, input int n);
    ncol = 0; col = '0;
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, bits[i]);
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses_before;
    rst = 1'b1; tck_in = 1'b0; tdi_in = 1'b0; tms_in = 1'b0; ncol = 0; col = '0;
    dr_capture_data = {16'hBEEF, 16'h1234, 16'h5A5A, 16'hC0DE};
    model_reset();
    wait_clks(4);
    chk("reset.tap_state", 32'(tap_state), 32'hF);
    chk("reset.ir_value", 32'(ir_value), 32'hF);
    chk("reset.tdo", 32'(tdo), 32'h0);
    chk("reset.vld", 32'(dr_update_vld), 32'h0);
    rst = 1'b0;
    wait_clks(PH);
    check_all("idle");

    tlr5();
    chk("tlr5.tap_state", 32'(tap_state), 32'hF);
    chk("tlr5.ir_value", 32'(ir_value), 32'hF);
    chk("tlr5.vld_count", 32'(vld_seen), 32'd0);

    scan_ir(4'h2);
    chk("capir.bit0", 32'(col[0]), 32'd1);
    chk("capir.bit1", 32'(col[1]), 32'd0);
    chk("ir2.ir_value", 32'(ir_value), 32'h2);

    scan_dr(32'h0000_A5C3, 16);
    chk("dr2.tdo_stream", 32'(col[15:0]), 32'h1234);
    chk("dr2.vld_count", 32'(vld_seen), 32'd1);
    chk("dr2.upd_data", 32'(dr_update_data), 32'hA5C3);
    chk("dr2.upd_sel", 32'(dr_update_sel), 32'h2);

    scan_ir(4'h9);
    chk("ir9.ir_value", 32'(ir_value), 32'h9);
    pulses_before = vld_seen;
    scan_dr(32'h0000_00B2, 9);
    chk("bypass.tdo_stream", 32'(col[8:0]), 32'h164);
    chk("bypass.no_pulse", 32'(vld_seen), 32'(pulses_before));

    scan_ir(4'h0);
    scan_dr(32'h0000_0F0F, 16);
    chk("dr0.tdo_stream", 32'(col[15:0]), 32'hC0DE);
    chk("dr0.upd_data", 32'(dr_update_data), 32'h0F0F);
    chk("dr0.upd_sel", 32'(dr_update_sel), 32'h0);
    chk("dr0.vld_count", 32'(vld_seen), 32'd2);

    // TCK held high through reset release must not be taken as an edge.
    tck_in = 1'b1; tms_in = 1'b0; rst = 1'b1;
    wait_clks(3);
    rst = 1'b0; model_reset();
    for (int i = 0; i < int'(SS) + 6; i++) begin
      wait_clks(1);
      chk("tckhigh.tap_state", 32'(tap_state), 32'hF);
    end
    tck_in = 1'b0; model_fall();
    wait_clks(PH);
    check_all("tckhigh");

    scan_ir(4'h2);
    pulses_before = vld_seen;
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tck_cycle(1'b0, 1'b1);
    chk("midscan.pre_state", 32'(tap_state), 32'h2);
    rst = 1'b1;
    wait_clks(1);
    chk("midscan.tap_state", 32'(tap_state), 32'hF);
    chk("midscan.ir_value", 32'(ir_value), 32'hF);
    chk("midscan.tdo", 32'(tdo), 32'h0);
    rst = 1'b0; model_reset();
    wait_clks(PH);
    check_all("post_rst");
    chk("midscan.no_pulse", 32'(vld_seen), 32'(pulses_before));
    tlr5();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
